mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32I core. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes: PC, IR, memory request,
//  register-file write, ALU operand/op select, and imm_sel for the sign/zero-extend unit.
//  Sits between the instruction register and the datapath; the datapath holds all state.
// PARAMETERS
//  CNT_W      32  width of retired-instruction counter instret
//  IMM_SEL_W  3   width of imm_sel (encodings in ctrl_pkg)
// PORTS
//  clk        in   1          system clock (50 MHz)
//  rst_n      in   1          synchronous reset, active low
//  inst       in   32         current IR contents (valid from DECODE onward)
//  mem_ready  in   1          memory completes request this cycle
//  alu_zero   in   1          ALU result == 0
//  alu_lt     in   1          ALU less-than (signed/unsigned per alu_op)
//  mem_req    out  1          memory request; held until mem_ready
//  mem_we     out  1          store qualifier for mem_req
//  ir_we      out  1          latch fetched word into IR
//  pc_we      out  1          update PC
//  pc_sel     out  1          0: PC+4, 1: ALU target
//  imm_sel    out  IMM_SEL_W  I/S/B/U/J immediate type
//  alu_src_a  out  1          0: rs1, 1: PC
//  alu_src_b  out  1          0: rs2, 1: immediate
//  alu_op     out  4          ALU function (ctrl_pkg encoding)
//  rf_we      out  1          register-file write enable, one cycle in WB
//  wb_sel     out  2          0: ALU, 1: load data, 2: PC+4
//  state      out  3          current FSM state (debug/LEDs)
//  instret    out  CNT_W      retired-instruction count
//  illegal    out  1          illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=FETCH, instret=0, illegal=0, all strobes 0;
//    outstanding mem_req dropped the following cycle; late mem_ready ignored.
//  - Strobes are combinational from state+inst; only state, instret, illegal are flops.
//  - FETCH: mem_req=1, mem_we=0. Stay until mem_ready; on mem_ready: ir_we=1, pc_we=1,
//    pc_sel=0 -> DECODE. mem_ready while mem_req=0 is ignored.
//  - DECODE: imm_sel from opcode (OP-IMM/LOAD/JALR=I, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J)
//    -> EXEC.
//  - EXEC: OP/OP-IMM/LUI/AUIPC -> WB. LOAD/STORE: alu_src_b=1 (address) -> MEM.
//    BRANCH: taken by funct3 (BEQ zero, BNE !zero, BLT/BLTU lt, BGE/BGEU !lt); taken ->
//    pc_we=1, pc_sel=1 (target PC+imm); -> FETCH. JAL/JALR: pc_we=1, pc_sel=1 -> WB (wb_sel=2).
//  - MEM: mem_req=1, mem_we=STORE; hold until mem_ready; LOAD -> WB, STORE -> FETCH.
//  - WB: rf_we=1 for one cycle (suppressed when rd==x0) -> FETCH.
//  - instret increments by 1 on every transition into FETCH from EXEC/MEM/WB; wraps at
//    2^CNT_W-1 -> 0. Unknown funct3 on BRANCH = not taken.
//  - Latency: ALU op 4 cycles, load 5, store 4, branch 3 (with 0-wait memory).
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP state; illegal=1, all strobes 0,
//    held until reset; instret frozen.
//  Not defined: unknown opcode is a NOP (DECODE -> EXEC -> FETCH, no writes, instret++);
//    illegal tied 0; TRAP state absent.
// STRUCTURE
//  - ctrl_pkg: opcode constants, state encoding, imm_sel encodings (shared with sz_ex),
//    alu_op and wb_sel encodings.
//  - Sub-module opcode_dec: combinational opcode/funct3/funct7 -> instruction class,
//    imm_sel, alu_op. FSM and counter live in mc_ctrl_fsm.
// TESTING
//  - Reset then ADDI x1,x0,5 (0x00500093), mem_ready=1 always: FETCH,DECODE,EXEC,WB;
//    rf_we=1 cycle 4, imm_sel=I, instret=1.
//  - LW with mem_ready held low 3 cycles in MEM: mem_req stays 1 for 4 cycles, rf_we
//    only after ready, wb_sel=1.
//  - BEQ (0x00208463) with alu_zero=1 -> pc_we=1,pc_sel=1 in EXEC; alu_zero=0 -> pc_we=0;
//    both 3 cycles.
//  - rst_n=0 mid-FETCH while mem_req=1: next cycle mem_req=0, state=FETCH, instret=0.
//  - Preload instret=2^CNT_W-1 (force), retire one instruction -> instret=0.
//  - inst=0x0000007F: with ILLEGAL_TRAP_EN illegal=1 and stuck until reset;
//    without it state returns to FETCH, no rf_we, illegal=0.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes, imm_sel (also used by the sign/zero-extend unit), alu_op and wb_sel.
package mc_ctrl_fsm_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_ILLEGAL
  } iclass_t;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Reserved funct3 codes (010/011) resolve to not-taken.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero, input logic lt);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Memory request bus between the controller (master) and the memory port (slave).
// Handshake: mem_req (with mem_we) is held high until the cycle mem_ready is high;
// that cycle completes the transfer. mem_ready while mem_req is low has no effect.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm_opcode_dec.sv
// Combinational decode of opcode/funct3/funct7 into instruction class,
// immediate type and the ALU function used in EXEC.
module opcode_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output iclass_t    iclass,
  output logic [2:0] imm_sel,
  output logic [3:0] alu_op
);

  logic [3:0] arith_op;

  // Shared by OP and OP-IMM; SUB is only distinguished for register-register ops.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    iclass  = CL_ILLEGAL;
    imm_sel = IMM_NONE;
    alu_op  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        iclass = CL_OP;
        alu_op = (funct3 == 3'b000 && funct7_b5) ? ALU_SUB : arith_op;
      end
      OPC_OPIMM: begin
        iclass  = CL_OPIMM;
        imm_sel = IMM_I;
        alu_op  = arith_op;
      end
      OPC_LOAD: begin
        iclass  = CL_LOAD;
        imm_sel = IMM_I;
      end
      OPC_STORE: begin
        iclass  = CL_STORE;
        imm_sel = IMM_S;
      end
      OPC_BRANCH: begin
        iclass  = CL_BRANCH;
        imm_sel = IMM_B;
        case (funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      OPC_LUI: begin
        iclass  = CL_LUI;
        imm_sel = IMM_U;
        alu_op  = ALU_PASSB;
      end
      OPC_AUIPC: begin
        iclass  = CL_AUIPC;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        iclass  = CL_JAL;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        iclass  = CL_JALR;
        imm_sel = IMM_I;
      end
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB strobes plus instret.
// Build option ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP instead of acting as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int IMM_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  mc_ctrl_fsm_if.master        mem,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [3:0]           alu_op,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     instret,
  output logic                 illegal
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  iclass_t          iclass;
  logic [2:0]       dec_imm_sel, imm_sel_c;
  logic [3:0]       dec_alu_op;
  logic             mem_req_c, mem_we_c, retire, taken;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{inst[31], inst[29:15]};

  opcode_dec u_dec (
    .opcode    (inst[6:0]),
    .funct3    (inst[14:12]),
    .funct7_b5 (inst[30]),
    .iclass    (iclass),
    .imm_sel   (dec_imm_sel),
    .alu_op    (dec_alu_op)
  );

  assign taken = branch_taken(inst[14:12], alu_zero, alu_lt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel_c = IMM_NONE;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_sel_c = dec_imm_sel;
        state_d   = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (iclass == CL_ILLEGAL) state_d = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        imm_sel_c = dec_imm_sel;
        alu_op    = dec_alu_op;
        state_d   = ST_WB;
        case (iclass)
          CL_OP: ;
          CL_OPIMM, CL_LUI: alu_src_b = 1'b1;
          CL_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b = 1'b1;
            state_d   = ST_MEM;
          end
          // ALU compares rs1/rs2; the datapath supplies the PC+imm target on pc_sel=1.
          CL_BRANCH: begin
            pc_we   = taken;
            pc_sel  = taken;
            state_d = ST_FETCH;
          end
          CL_JAL: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
          end
          CL_JALR: begin
            alu_src_b = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (iclass == CL_STORE);
        if (mem.mem_ready) state_d = (iclass == CL_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        rf_we   = (inst[11:7] != 5'd0);
        state_d = ST_FETCH;
        if (iclass == CL_LOAD) wb_sel = WB_LOAD;
        else if (iclass == CL_JAL || iclass == CL_JALR) wb_sel = WB_PC4;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase
    // Strobes are forced off while reset is held so a pending request is withdrawn.
    if (!rst_n) begin
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      imm_sel_c = IMM_NONE;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
    end
  end

  assign retire = (state_d == ST_FETCH) &&
                  (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB);

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign imm_sel     = IMM_SEL_W'(imm_sel_c);
  assign state       = state_q;
  assign instret     = instret_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (state_d == ST_TRAP) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: cycle-by-cycle vector table plus reset, counter-wrap
// and illegal-opcode sequences (the latter follows ILLEGAL_TRAP_EN).
module tb_mc_ctrl_fsm;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
  localparam logic [2:0] IM_I = 3'd1, IM_S = 3'd2, IM_B = 3'd3, IM_J = 3'd5;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd3;

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,8
  localparam logic [31:0] I_BGE  = 32'h0020D463;  // bge  x1,x2,8
  localparam logic [31:0] I_BLT  = 32'h0020C463;  // blt  x1,x2,8
  localparam logic [31:0] I_SW   = 32'h0020A023;  // sw   x2,0(x1)
  localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal  x1,8
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_NOP  = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        rdy, alu_zero, alu_lt;

  logic        ir_we, pc_we, pc_sel, alu_src_a, alu_src_b, rf_we, illegal;
  logic [2:0]  imm_sel, state;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [31:0] instret;

  logic        s_ir_we, s_pc_we, s_pc_sel, s_alu_src_a, s_alu_src_b, s_rf_we, s_illegal;
  logic [2:0]  s_imm_sel, s_state;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_wb_sel;
  logic [1:0]  s_instret;

  int checks = 0;
  int failures = 0;

  mc_ctrl_fsm_if bus ();
  mc_ctrl_fsm_if bus_s ();
  assign bus.mem_ready   = rdy;
  assign bus_s.mem_ready = rdy;

  mc_ctrl_fsm #(.CNT_W(32), .IMM_SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem(bus), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .state(state), .instret(instret), .illegal(illegal)
  );

  // Narrow-counter instance driven in lockstep to exercise instret wrap-around.
  mc_ctrl_fsm #(.CNT_W(2), .IMM_SEL_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem(bus_s), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel), .imm_sel(s_imm_sel),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .rf_we(s_rf_we),
    .wb_sel(s_wb_sel), .state(s_state), .instret(s_instret), .illegal(s_illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] act_v;
  assign act_v = {state, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_sel, imm_sel,
                  alu_src_a, alu_src_b, alu_op, rf_we, wb_sel};

  typedef struct packed {
    logic [31:0] inst;
    logic        rdy;
    logic        zero;
    logic        lt;
    logic [19:0] exp_v;
    logic [31:0] exp_ir;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] ev(input logic [2:0] st, input logic req, input logic we,
                                     input logic irwe, input logic pcwe, input logic pcsel,
                                     input logic [2:0] imm, input logic sa, input logic sb,
                                     input logic [3:0] op, input logic rf, input logic [1:0] wb);
    return {st, req, we, irwe, pcwe, pcsel, imm, sa, sb, op, rf, wb};
  endfunction

  task automatic add(input logic [31:0] i, input logic r, input logic z, input logic l,
                     input logic [19:0] e, input logic [31:0] ir);
    vec_t v;
    v.inst = i; v.rdy = r; v.zero = z; v.lt = l; v.exp_v = e; v.exp_ir = ir;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst = 32'h0; rdy = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;

    // ADDI: FETCH, DECODE, EXEC, WB
    add(I_ADDI, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 0);
    add(I_ADDI, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_I, 0, 0, OP_ADD, 0, 0), 0);
    add(I_ADDI, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_I, 0, 1, OP_ADD, 0, 0), 0);
    add(I_ADDI, 1, 0, 0, ev(S_W, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 1, 0), 0);
    // LW: one fetch wait, three MEM waits
    add(I_LW, 0, 0, 0, ev(S_F, 1, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 1);
    add(I_LW, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 1);
    add(I_LW, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_I, 0, 0, OP_ADD, 0, 0), 1);
    add(I_LW, 0, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_I, 0, 1, OP_ADD, 0, 0), 1);
    for (int k = 0; k < 3; k++)
      add(I_LW, 0, 0, 0, ev(S_M, 1, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0), 1);
    add(I_LW, 1, 0, 0, ev(S_M, 1, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 1);
    add(I_LW, 1, 0, 0, ev(S_W, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 1, 1), 1);
    // BEQ taken, BEQ not taken, BGE taken, BLT not taken
    add(I_BEQ, 1, 1, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 2);
    add(I_BEQ, 1, 1, 0, ev(S_D, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_ADD, 0, 0), 2);
    add(I_BEQ, 1, 1, 0, ev(S_E, 0, 0, 0, 1, 1, IM_B, 0, 0, OP_SUB, 0, 0), 2);
    add(I_BEQ, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 3);
    add(I_BEQ, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_ADD, 0, 0), 3);
    add(I_BEQ, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_SUB, 0, 0), 3);
    add(I_BGE, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 4);
    add(I_BGE, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_ADD, 0, 0), 4);
    add(I_BGE, 1, 0, 0, ev(S_E, 0, 0, 0, 1, 1, IM_B, 0, 0, OP_SLT, 0, 0), 4);
    add(I_BLT, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 5);
    add(I_BLT, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_ADD, 0, 0), 5);
    add(I_BLT, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_B, 0, 0, OP_SLT, 0, 0), 5);
    // SW: four cycles, store qualifier in MEM
    add(I_SW, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 6);
    add(I_SW, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_S, 0, 0, OP_ADD, 0, 0), 6);
    add(I_SW, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_S, 0, 1, OP_ADD, 0, 0), 6);
    add(I_SW, 1, 0, 0, ev(S_M, 1, 1, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 6);
    // JAL: jump in EXEC, link in WB
    add(I_JAL, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 7);
    add(I_JAL, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_J, 0, 0, OP_ADD, 0, 0), 7);
    add(I_JAL, 1, 0, 0, ev(S_E, 0, 0, 0, 1, 1, IM_J, 1, 1, OP_ADD, 0, 0), 7);
    add(I_JAL, 1, 0, 0, ev(S_W, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 1, 2), 7);
    // SUB: register-register, funct7 selects subtract
    add(I_SUB, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 8);
    add(I_SUB, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 8);
    add(I_SUB, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, 0,    0, 0, OP_SUB, 0, 0), 8);
    add(I_SUB, 1, 0, 0, ev(S_W, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 1, 0), 8);
    // ADDI to x0: write suppressed
    add(I_NOP, 1, 0, 0, ev(S_F, 1, 0, 1, 1, 0, 0,    0, 0, OP_ADD, 0, 0), 9);
    add(I_NOP, 1, 0, 0, ev(S_D, 0, 0, 0, 0, 0, IM_I, 0, 0, OP_ADD, 0, 0), 9);
    add(I_NOP, 1, 0, 0, ev(S_E, 0, 0, 0, 0, 0, IM_I, 0, 1, OP_ADD, 0, 0), 9);
    add(I_NOP, 1, 0, 0, ev(S_W, 0, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 9);
    add(I_NOP, 0, 0, 0, ev(S_F, 1, 0, 0, 0, 0, 0,    0, 0, OP_ADD, 0, 0), 10);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", act_v, 20'h0);
    chk("reset_instret", instret, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_instret_narrow", s_instret, 0);

    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      inst = tbl[i].inst; rdy = tbl[i].rdy; alu_zero = tbl[i].zero; alu_lt = tbl[i].lt;
      #1;
      chk($sformatf("vec%0d_strobes", i), act_v, tbl[i].exp_v);
      chk($sformatf("vec%0d_instret", i), instret, tbl[i].exp_ir);
      next_cycle();
    end

    // Reset asserted mid-FETCH with a late mem_ready
    rst_n = 1'b0; rdy = 1'b1;
    #1;
    chk("rst_mid_req_during", bus.mem_req, 0);
    next_cycle();
    chk("rst_mid_state", state, S_F);
    chk("rst_mid_req_after", bus.mem_req, 0);
    chk("rst_mid_instret", instret, 0);
    rst_n = 1'b1; rdy = 1'b0;
    #1;
    chk("rst_release_req", bus.mem_req, 1);

    // Counter wrap: narrow instance reaches 2^2-1, then wraps to 0
    inst = I_ADDI; rdy = 1'b1;
    #1;
    repeat (12) next_cycle();
    chk("wrap_pre_narrow", s_instret, 3);
    chk("wrap_pre_wide", instret, 3);
    repeat (4) next_cycle();
    chk("wrap_narrow", s_instret, 0);
    chk("wrap_wide", instret, 4);
    chk("wrap_state", state, S_F);

    // Unknown opcode
    inst = I_BAD; rdy = 1'b1;
    next_cycle();
    chk("bad_decode", act_v, ev(S_D, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0));
    next_cycle();
`ifdef ILLEGAL_TRAP_EN
    chk("bad_trap", act_v, ev(S_T, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0));
    chk("bad_trap_illegal", illegal, 1);
    repeat (5) next_cycle();
    chk("bad_trap_stuck", act_v, ev(S_T, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0));
    chk("bad_trap_illegal_stuck", illegal, 1);
    chk("bad_trap_instret_frozen", instret, 4);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("bad_trap_reset_illegal", illegal, 0);
    chk("bad_trap_reset_state", state, S_F);
`else
    chk("bad_exec_nop", act_v, ev(S_E, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0));
    chk("bad_exec_illegal", illegal, 0);
    next_cycle();
    chk("bad_back_fetch", state, S_F);
    chk("bad_instret", instret, 5);
    chk("bad_illegal_after", illegal, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
